// File: rtl/registers_unit_sb.sv
// registers_unit_sb: integer register file with per-register scoreboard.
//   XLEN-bit x NREGS registers, x0 hardwired to zero, NREAD combinational
//   read ports, one synchronous write port, optional write-to-read forwarding.
//   A pending bit per register is set at issue and cleared at writeback.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rs / ru_rs / rs_busy  packed read indices, read data, per-port hazard flag
//   rd, DataWR, RUWr      writeback index, data, enable
//   issue_valid, issue_rd issue of an instruction producing issue_rd
//   busy_count            registered number of pending registers
module registers_unit_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2,
  parameter int unsigned FWD   = 1,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREAD*AW-1:0]           rs,
  output logic [NREAD*XLEN-1:0]         ru_rs,
  output logic [NREAD-1:0]              rs_busy,
  input  logic [AW-1:0]                 rd,
  input  logic [XLEN-1:0]               DataWR,
  input  logic                          RUWr,
  input  logic                          issue_valid,
  input  logic [AW-1:0]                 issue_rd,
  output logic [$clog2(NREGS+1)-1:0]    busy_count
);

  localparam int unsigned CW = $clog2(NREGS + 1);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [CW-1:0]    count_nxt;
  logic             wr_en;

  assign wr_en = RUWr && (rd != '0);

  // Register array; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd] <= DataWR;
    end
  end

  // Scoreboard next state: writeback clears, issue sets afterwards so that
  // a new producer issued alongside the old one's writeback stays pending.
  always_comb begin
    pending_nxt = pending;
    if (wr_en) pending_nxt[rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Popcount of the next-state vector so busy_count tracks pending exactly.
  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < NREGS; i++) count_nxt = count_nxt + CW'(pending_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      busy_count <= '0;
    end else begin
      pending    <= pending_nxt;
      busy_count <= count_nxt;
    end
  end

  // Read ports: x0 first, then same-cycle forward, then committed state.
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] idx;
    logic          hit;
    assign idx  = rs[g*AW +: AW];
    assign hit  = (FWD != 0) && RUWr && (rd == idx);
    assign ru_rs[g*XLEN +: XLEN] = (idx == '0) ? '0 : (hit ? DataWR : regs[idx]);
    // A forwarded result resolves the hazard in the same cycle.
    assign rs_busy[g] = (idx != '0) && pending[idx] && !hit;
  end

endmodule

// File: tb/tb_registers_unit_sb.sv
module tb_registers_unit_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NREAD = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 6;

  logic                    clk;
  logic                    rst_n;
  logic [NREAD*AW-1:0]     rs;
  logic [NREAD*XLEN-1:0]   ru_rs, ru_rs_nf;
  logic [NREAD-1:0]        rs_busy, rs_busy_nf;
  logic [AW-1:0]           rd;
  logic [XLEN-1:0]         data;
  logic                    ruwr;
  logic                    iv;
  logic [AW-1:0]           ird;
  logic [CW-1:0]           cnt, cnt_nf;

  registers_unit_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .FWD(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .ru_rs(ru_rs), .rs_busy(rs_busy),
    .rd(rd), .DataWR(data), .RUWr(ruwr), .issue_valid(iv), .issue_rd(ird),
    .busy_count(cnt));

  registers_unit_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .FWD(0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .rs(rs), .ru_rs(ru_rs_nf), .rs_busy(rs_busy_nf),
    .rd(rd), .DataWR(data), .RUWr(ruwr), .issue_valid(iv), .issue_rd(ird),
    .busy_count(cnt_nf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: architectural values and the set of outstanding producers.
  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_pend [NREGS];

  typedef struct {
    logic                      ruwr;
    logic [AW-1:0]             rd;
    logic [XLEN-1:0]           data;
    logic                      iv;
    logic [AW-1:0]             ird;
    logic [NREAD-1:0][AW-1:0]  rs;
    logic [NREAD-1:0][XLEN-1:0] er;
    logic [NREAD-1:0]          ebusy;
    logic [CW-1:0]             ecnt;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(logic w, logic [4:0] d, logic [31:0] dat, logic i, logic [4:0] ir,
                              logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                              logic [2:0] b, logic [5:0] c);
    vec_t v;
    v.ruwr = w; v.rd = d; v.data = dat; v.iv = i; v.ird = ir;
    v.rs[0] = r0; v.rs[1] = r1; v.rs[2] = r2;
    v.er[0] = e0; v.er[1] = e1; v.er[2] = e2;
    v.ebusy = b; v.ecnt = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(bit fwd, logic [AW-1:0] s);
    if (s == 0) return 32'h0;
    if (fwd && ruwr && rd == s) return data;
    return m_reg[s];
  endfunction

  function automatic logic exp_busy(bit fwd, logic [AW-1:0] s);
    return (s != 0) && m_pend[s] && !(fwd && ruwr && rd == s);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (ruwr && rd != 0) begin
        m_reg[rd] = data;
        m_pend[rd] = 1'b0;
      end
      if (iv && ird != 0) m_pend[ird] = 1'b1;
    end
  endtask

  task automatic check_model_comb(input bit with_fwd_inst);
    for (int p = 0; p < NREAD; p++) begin
      logic [AW-1:0] s;
      s = rs[p*AW +: AW];
      if (with_fwd_inst) begin
        check($sformatf("fwd rd p%0d x%0d", p, s), ru_rs[p*XLEN +: XLEN], exp_rd(1'b1, s));
        check($sformatf("fwd busy p%0d x%0d", p, s), 32'(rs_busy[p]), 32'(exp_busy(1'b1, s)));
      end
      check($sformatf("nofwd rd p%0d x%0d", p, s), ru_rs_nf[p*XLEN +: XLEN], exp_rd(1'b0, s));
      check($sformatf("nofwd busy p%0d x%0d", p, s), 32'(rs_busy_nf[p]), 32'(exp_busy(1'b0, s)));
    end
  endtask

  task automatic check_counts();
    check("busy_count fwd", 32'(cnt), 32'(m_count()));
    check("busy_count nofwd", 32'(cnt_nf), 32'(m_count()));
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle(input bit fwd_vs_model);
    #1 check_model_comb(fwd_vs_model);
    @(posedge clk);
    model_edge();
    #1 check_counts();
    @(negedge clk);
  endtask

  task automatic apply(input logic w, input logic [AW-1:0] d, input logic [XLEN-1:0] dat,
                       input logic i, input logic [AW-1:0] ir, input logic [NREAD*AW-1:0] r);
    ruwr = w; rd = d; data = dat; iv = i; ird = ir; rs = r;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    tbl[1]  = mk(1, 5, 32'h4, 0, 0, 5, 0, 0, 32'h4, 0, 0, 3'b000, 0);
    tbl[2]  = mk(1, 7, 32'd13, 0, 0, 5, 7, 5, 32'h4, 32'd13, 32'h4, 3'b000, 0);
    tbl[3]  = mk(0, 0, 0, 1, 9, 5, 7, 9, 32'h4, 32'd13, 0, 3'b000, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 9, 9, 0, 0, 0, 0, 3'b011, 1);
    tbl[5]  = mk(1, 9, 32'h55, 0, 0, 9, 5, 9, 32'h55, 32'h4, 32'h55, 3'b000, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 9, 0, 7, 32'h55, 0, 32'd13, 3'b000, 0);
    tbl[7]  = mk(1, 9, 32'h77, 1, 9, 9, 9, 9, 32'h77, 32'h77, 32'h77, 3'b000, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 9, 0, 0, 32'h77, 0, 0, 3'b001, 1);
    tbl[9]  = mk(0, 0, 0, 1, 9, 9, 0, 0, 32'h77, 0, 0, 3'b001, 1);
    tbl[10] = mk(1, 12, 32'hABC, 1, 3, 12, 3, 9, 32'hABC, 0, 32'h77, 3'b100, 2);
    tbl[11] = mk(1, 3, 32'h33, 0, 0, 3, 12, 9, 32'h33, 32'hABC, 32'h77, 3'b100, 1);

    rst_n = 1'b0;
    apply(0, 0, 0, 0, 0, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1 check("reset busy_count", 32'(cnt), 32'h0);
    check("reset rs_busy", 32'(rs_busy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table from a clean state.
    for (int k = 0; k < 12; k++) begin
      apply(tbl[k].ruwr, tbl[k].rd, tbl[k].data, tbl[k].iv, tbl[k].ird, tbl[k].rs);
      #1;
      for (int p = 0; p < NREAD; p++)
        check($sformatf("tbl%0d rd p%0d", k, p), ru_rs[p*XLEN +: XLEN], tbl[k].er[p]);
      check($sformatf("tbl%0d busy", k), 32'(rs_busy), 32'(tbl[k].ebusy));
      check_model_comb(1'b0);
      @(posedge clk);
      model_edge();
      #1 check($sformatf("tbl%0d count", k), 32'(cnt), 32'(tbl[k].ecnt));
      check_counts();
      @(negedge clk);
    end

    // Randomised traffic on a narrow index range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      logic [NREAD*AW-1:0] r;
      for (int p = 0; p < NREAD; p++) r[p*AW +: AW] = AW'($urandom_range(0, 11));
      apply(1'($urandom_range(0, 1)), AW'($urandom_range(0, 11)), $urandom,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 11)), r);
      cycle(1'b1);
    end

    // Reset: populate state, then assert reset while a write is presented.
    apply(1, 5, 32'hDEADBEEF, 1, 6, {5'd0, 5'd0, 5'd0});
    cycle(1'b1);
    apply(1, 8, 32'h12345678, 1, 8, {5'd8, 5'd6, 5'd5});
    rst_n = 1'b0;
    model_reset();
    #1 check_model_comb(1'b1);
    check("reset async count", 32'(cnt), 32'h0);
    @(posedge clk);
    #1;
    apply(0, 0, 0, 0, 0, {5'd8, 5'd6, 5'd5});
    #1 check("reset discards write x8", ru_rs[2*XLEN +: XLEN], 32'h0);
    check("reset x5 cleared", ru_rs[0 +: XLEN], 32'h0);
    check("reset rs_busy clear", 32'(rs_busy), 32'h0);
    check("reset count held", 32'(cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
